// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin values,
// FSM state encoding and the timer width.
package change_dispenser_pkg;

  localparam logic [2:0] COIN_1 = 3'b001;
  localparam logic [2:0] COIN_2 = 3'b010;
  localparam logic [2:0] COIN_5 = 3'b100;

  localparam logic [7:0] VAL_1 = 8'd1;
  localparam logic [7:0] VAL_2 = 8'd2;
  localparam logic [7:0] VAL_5 = 8'd5;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [7:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_1:  coin_value = VAL_1;
      COIN_2:  coin_value = VAL_2;
      COIN_5:  coin_value = VAL_5;
      default: coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// Loadable down-counter; zero is high while the count is at 0.
// A load takes priority over counting.
module change_dispenser_pulse_timer
  import change_dispenser_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount as timed coin pulses from a 5/2/1 zl hopper,
// greedy largest-coin-first, tracking per-tube stock.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for change_valid; refill accepted here only
// S_SELECT | pick largest stocked coin <= remaining, or finish
// S_PULSE  | coin_out held high for PULSE_CYCLES
// S_GAP    | coin_out low for GAP_CYCLES before next selection
// S_DONE   | one-cycle done pulse, shortfall/error registered
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int CNT_W        = 8,
  parameter int INIT_CNT     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       change_valid,
  input  logic [7:0] change_amount,
  input  logic       refill,
  output logic [2:0] coin_out,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] shortfall,
  output logic [2:0] tube_empty
);

  state_t             state;
  logic [7:0]         remaining;
  logic [CNT_W-1:0]   tube_1;
  logic [CNT_W-1:0]   tube_2;
  logic [CNT_W-1:0]   tube_5;
  logic [2:0]         pick;
  logic [7:0]         pick_val;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_zero;

  // Greedy choice; the <= remaining test keeps remaining from underflowing.
  always_comb begin
    pick = 3'b000;
    if (remaining >= VAL_5 && tube_5 != '0) begin
      pick = COIN_5;
    end else if (remaining >= VAL_2 && tube_2 != '0) begin
      pick = COIN_2;
    end else if (remaining >= VAL_1 && tube_1 != '0) begin
      pick = COIN_1;
    end
  end

  assign pick_val = coin_value(pick);

  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    if (state == S_SELECT && pick != 3'b000) begin
      timer_load = 1'b1;
      timer_val  = TIMER_W'(PULSE_CYCLES - 1);
    end else if (state == S_PULSE && timer_zero) begin
      timer_load = 1'b1;
      timer_val  = TIMER_W'(GAP_CYCLES - 1);
    end
  end

  change_dispenser_pulse_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= 8'd0;
      coin_out  <= 3'b000;
      done      <= 1'b0;
      error     <= 1'b0;
      shortfall <= 8'd0;
      tube_1    <= CNT_W'(INIT_CNT);
      tube_2    <= CNT_W'(INIT_CNT);
      tube_5    <= CNT_W'(INIT_CNT);
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (refill) begin
            tube_1 <= CNT_W'(INIT_CNT);
            tube_2 <= CNT_W'(INIT_CNT);
            tube_5 <= CNT_W'(INIT_CNT);
          end
          if (change_valid) begin
            remaining <= change_amount;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (pick != 3'b000) begin
            coin_out  <= pick;
            remaining <= remaining - pick_val;
            state     <= S_PULSE;
            case (pick)
              COIN_5:  tube_5 <= tube_5 - CNT_W'(1);
              COIN_2:  tube_2 <= tube_2 - CNT_W'(1);
              default: tube_1 <= tube_1 - CNT_W'(1);
            endcase
          end else begin
            // Either fully paid or nothing left that fits: report what is owed.
            done      <= 1'b1;
            shortfall <= remaining;
            error     <= (remaining != 8'd0);
            state     <= S_DONE;
          end
        end
        S_PULSE: begin
          if (timer_zero) begin
            coin_out <= 3'b000;
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          if (timer_zero) begin
            state <= S_SELECT;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          coin_out <= 3'b000;
        end
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign tube_empty = {tube_5 == '0, tube_2 == '0, tube_1 == '0};

endmodule
